// File: rtl/wb_load_stage_if.sv
// MEM -> WB instruction bundle for the write-back load stage.
// The MEM stage drives the master side; wb_load_stage is the slave side.
interface wb_load_stage_if #(
  parameter int RF_AW = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_memtoreg;
  logic [3:0]       in_lsop;
  logic [1:0]       in_addr_lo;
  logic [31:0]      in_result;
  logic [31:0]      in_rt_old;
  logic [RF_AW-1:0] in_wnum;
  logic             in_wen;

  modport master (
    output in_valid, in_memtoreg, in_lsop, in_addr_lo,
           in_result, in_rt_old, in_wnum, in_wen,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_memtoreg, in_lsop, in_addr_lo,
           in_result, in_rt_old, in_wnum, in_wen,
    output in_ready
  );
endinterface

// File: rtl/wb_load_stage.sv
// MEM/WB pipeline register and load-data formatter.
// Holds one MEM-stage instruction, formats the SRAM read data that arrives the
// cycle after transfer (byte/half/word plus LWL/LWR merges), keeps that data in
// a skid register while WB is stalled, flags misaligned loads and counts
// retired loads.
module wb_load_stage #(
  parameter int RF_AW      = 5,
  parameter int CNT_W      = 32,
  parameter int EN_UNALIGN = 1
) (
  input  logic               clk,
  input  logic               resetn,
  wb_load_stage_if.slave     mem,
  input  logic               flush,
  input  logic               wb_stall,
  input  logic [31:0]        mem_rdata,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               exc_adel,
  output logic [CNT_W-1:0]   ld_cnt
);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LBU = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_LWL = 4'b0101;
  localparam logic [3:0] OP_LWR = 4'b0110;

  // stage register contents
  logic              s_valid_r;
  logic [3:0]        s_op_r;
  logic [1:0]        s_addr_r;
  logic [31:0]       s_result_r;
  logic [31:0]       s_rt_r;
  logic [RF_AW-1:0]  s_wnum_r;
  logic              s_wen_r;
  logic              s_mtr_r;

  // skid buffer for read data captured on the first stalled cycle
  logic              hold_valid_r;
  logic [31:0]       hold_data_r;

  logic [CNT_W-1:0]  ld_cnt_r;

  logic [31:0]       data_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [31:0]       fmt_s;
  logic              adel_s;
  logic              we_s;

  assign mem.in_ready = ~wb_stall;

  // stage register: loads on transfer, empties when WB advances with no input,
  // frozen under stall; flush drops whatever would arrive this cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_valid_r  <= 1'b0;
      s_op_r     <= 4'b0000;
      s_addr_r   <= 2'b00;
      s_result_r <= 32'h0000_0000;
      s_rt_r     <= 32'h0000_0000;
      s_wnum_r   <= {RF_AW{1'b0}};
      s_wen_r    <= 1'b0;
      s_mtr_r    <= 1'b0;
    end else if (flush) begin
      s_valid_r <= 1'b0;
    end else if (!wb_stall) begin
      s_valid_r <= mem.in_valid;
      if (mem.in_valid) begin
        s_op_r     <= mem.in_lsop;
        s_addr_r   <= mem.in_addr_lo;
        s_result_r <= mem.in_result;
        s_rt_r     <= mem.in_rt_old;
        s_wnum_r   <= mem.in_wnum;
        s_wen_r    <= mem.in_wen;
        s_mtr_r    <= mem.in_memtoreg;
      end
    end
  end

  // skid: SRAM data is only valid one cycle, so capture it on the first stalled cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 32'h0000_0000;
    end else if (flush || !wb_stall) begin
      hold_valid_r <= 1'b0;
    end else if (s_valid_r && !hold_valid_r) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= mem_rdata;
    end
  end

  // data source selection and byte/half extraction
  always_comb begin
    data_s = hold_valid_r ? hold_data_r : mem_rdata;
    byte_s = 8'h00;
    case (s_addr_r)
      2'd0:    byte_s = data_s[7:0];
      2'd1:    byte_s = data_s[15:8];
      2'd2:    byte_s = data_s[23:16];
      2'd3:    byte_s = data_s[31:24];
      default: byte_s = 8'h00;
    endcase
    if (s_addr_r[1]) begin
      half_s = data_s[31:16];
    end else begin
      half_s = data_s[15:0];
    end
  end

  // load formatting including LWL/LWR merges with the old rt value
  always_comb begin
    fmt_s = 32'h0000_0000;
    case (s_op_r)
      OP_LB:  fmt_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU: fmt_s = {24'h00_0000, byte_s};
      OP_LH:  fmt_s = {{16{half_s[15]}}, half_s};
      OP_LHU: fmt_s = {16'h0000, half_s};
      OP_LW:  fmt_s = data_s;
      OP_LWL: begin
        if (EN_UNALIGN != 0) begin
          case (s_addr_r)
            2'd0:    fmt_s = {data_s[7:0],  s_rt_r[23:0]};
            2'd1:    fmt_s = {data_s[15:0], s_rt_r[15:0]};
            2'd2:    fmt_s = {data_s[23:0], s_rt_r[7:0]};
            2'd3:    fmt_s = data_s;
            default: fmt_s = 32'h0000_0000;
          endcase
        end else begin
          fmt_s = 32'h0000_0000;
        end
      end
      OP_LWR: begin
        if (EN_UNALIGN != 0) begin
          case (s_addr_r)
            2'd0:    fmt_s = data_s;
            2'd1:    fmt_s = {s_rt_r[31:24], data_s[31:8]};
            2'd2:    fmt_s = {s_rt_r[31:16], data_s[31:16]};
            2'd3:    fmt_s = {s_rt_r[31:8],  data_s[31:24]};
            default: fmt_s = 32'h0000_0000;
          endcase
        end else begin
          fmt_s = 32'h0000_0000;
        end
      end
      default: fmt_s = 32'h0000_0000;
    endcase
  end

  // misaligned half/word loads fault; bytes and LWL/LWR never do
  always_comb begin
    adel_s = 1'b0;
    if (s_valid_r && s_mtr_r) begin
      case (s_op_r)
        OP_LH, OP_LHU: adel_s = s_addr_r[0];
        OP_LW:         adel_s = (s_addr_r != 2'b00);
        default:       adel_s = 1'b0;
      endcase
    end else begin
      adel_s = 1'b0;
    end
  end

  // write enable: suppressed by stall, fault, or a write to r0
  always_comb begin
    we_s = s_valid_r & s_wen_r & ~wb_stall & ~adel_s & (s_wnum_r != {RF_AW{1'b0}});
  end

  // retired-load counter, wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_cnt_r <= {CNT_W{1'b0}};
    end else if (we_s && s_mtr_r) begin
      ld_cnt_r <= ld_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rf_we    = we_s;
  assign rf_waddr = s_wnum_r;
  assign rf_wdata = s_mtr_r ? fmt_s : s_result_r;
  assign exc_adel = adel_s;
  assign ld_cnt   = ld_cnt_r;

endmodule

// File: tb/tb_wb_load_stage.sv
// Bench for wb_load_stage: vector table, directed stall/flush/wrap/reset
// sequences and randomized traffic against a behavioural model.
module tb_wb_load_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        wb_stall;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        exc_adel;
  logic [3:0]  ld_cnt;

  int total;
  int bad;

  wb_load_stage_if #(.RF_AW(5)) bus ();

  wb_load_stage #(.RF_AW(5), .CNT_W(4), .EN_UNALIGN(1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem       (bus.slave),
    .flush     (flush),
    .wb_stall  (wb_stall),
    .mem_rdata (mem_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .exc_adel  (exc_adel),
    .ld_cnt    (ld_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model of the instruction sitting in WB: its read data is whatever
  // mem_rdata showed on the first cycle it was visible
  typedef struct {
    bit          v;
    bit          fresh;
    logic        mtr;
    logic [3:0]  op;
    logic [1:0]  a;
    logic [31:0] res;
    logic [31:0] rt;
    logic [31:0] data;
    logic [4:0]  wnum;
    logic        wen;
  } ent_t;

  ent_t ent;
  int   cnt_m;

  typedef struct {
    logic        mtr;
    logic [3:0]  op;
    logic [1:0]  a;
    logic [31:0] res;
    logic [31:0] rt;
    logic [4:0]  wnum;
    logic        wen;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_adel;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fmt(input int op, input int a,
                                          input logic [31:0] d, input logic [31:0] rt);
    logic [31:0] b;
    logic [31:0] h;
    int sh;
    sh = 8 * a;
    b = (d >> sh) & 32'h0000_00FF;
    h = (d >> (16 * (a / 2))) & 32'h0000_FFFF;
    case (op)
      0:       return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      1:       return b;
      2:       return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3:       return h;
      4:       return d;
      5:       return (d << (24 - sh)) | (rt & (32'h00FF_FFFF >> sh));
      6:       return (d >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic drive(input logic v, input logic mtr, input logic [3:0] op, input logic [1:0] a,
                       input logic [31:0] res, input logic [31:0] rt, input logic [4:0] wnum,
                       input logic wen);
    bus.in_valid    = v;
    bus.in_memtoreg = mtr;
    bus.in_lsop     = op;
    bus.in_addr_lo  = a;
    bus.in_result   = res;
    bus.in_rt_old   = rt;
    bus.in_wnum     = wnum;
    bus.in_wen      = wen;
  endtask

  // one clock cycle, entered and left at the falling edge; checks model vs DUT
  task automatic tick();
    logic        e_adel;
    logic        e_we;
    logic [31:0] e_wd;
    #1;
    if (ent.v && ent.fresh) begin
      ent.data  = mem_rdata;
      ent.fresh = 1'b0;
    end
    e_adel = ent.v && ent.mtr &&
             (((ent.op == 4'd2 || ent.op == 4'd3) && ent.a[0]) || (ent.op == 4'd4 && ent.a != 2'd0));
    e_we   = ent.v && ent.wen && !wb_stall && !e_adel && (ent.wnum != 5'd0);
    e_wd   = ent.mtr ? ref_fmt(int'(ent.op), int'(ent.a), ent.data, ent.rt) : ent.res;
    chk("m_rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("m_exc_adel", {31'd0, exc_adel}, {31'd0, e_adel});
    chk("m_ld_cnt", {28'd0, ld_cnt}, 32'(cnt_m));
    chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, ~wb_stall});
    if (e_we) begin
      chk("m_rf_wdata", rf_wdata, e_wd);
      chk("m_rf_waddr", {27'd0, rf_waddr}, {27'd0, ent.wnum});
    end
    @(posedge clk);
    if (resetn) begin
      if (e_we && ent.mtr) cnt_m = (cnt_m + 1) % 16;
      if (flush) begin
        ent.v = 1'b0;
      end else if (!wb_stall) begin
        if (bus.in_valid) begin
          ent.v     = 1'b1;
          ent.fresh = 1'b1;
          ent.mtr   = bus.in_memtoreg;
          ent.op    = bus.in_lsop;
          ent.a     = bus.in_addr_lo;
          ent.res   = bus.in_result;
          ent.rt    = bus.in_rt_old;
          ent.wnum  = bus.in_wnum;
          ent.wen   = bus.in_wen;
        end else begin
          ent.v = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  // asynchronous reset in the middle of a cycle; outputs must clear at once
  task automatic mid_reset(input string tag);
    #2;
    resetn = 1'b0;
    #1;
    chk({tag, "_rf_we"},    {31'd0, rf_we},    32'd0);
    chk({tag, "_exc_adel"}, {31'd0, exc_adel}, 32'd0);
    chk({tag, "_ld_cnt"},   {28'd0, ld_cnt},   32'd0);
    chk({tag, "_rf_wdata"}, rf_wdata,          32'd0);
    chk({tag, "_rf_waddr"}, {27'd0, rf_waddr}, 32'd0);
    ent.v = 1'b0;
    ent.fresh = 1'b0;
    cnt_m = 0;
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    flush = 1'b0;
    wb_stall = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cnt_m = 0;
    ent   = '{default: '0};
    resetn = 1'b0;
    flush = 1'b0;
    wb_stall = 1'b0;
    mem_rdata = 32'd0;
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);

    //            mtr   op     a      result        rt_old        wnum   wen   rdata         exp_wdata     we    adel
    vecs[0]  = '{1'b1, 4'd0, 2'd3, 32'h0,        32'h0,        5'd5,  1'b1, 32'h8012_3456, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 2'd3, 32'h0,        32'h0,        5'd5,  1'b1, 32'h8012_3456, 32'h0000_0080, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'd0, 2'd0, 32'h0,        32'h0,        5'd6,  1'b1, 32'h8012_3456, 32'h0000_0056, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'd2, 2'd2, 32'h0,        32'h0,        5'd7,  1'b1, 32'h8012_3456, 32'hFFFF_8012, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'd3, 2'd0, 32'h0,        32'h0,        5'd8,  1'b1, 32'h8012_3456, 32'h0000_3456, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd4, 2'd0, 32'h0,        32'h0,        5'd9,  1'b1, 32'h8012_3456, 32'h8012_3456, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd5, 2'd1, 32'h0,        32'hAABBCCDD, 5'd10, 1'b1, 32'h1122_3344, 32'h3344_CCDD, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd6, 2'd2, 32'h0,        32'hAABBCCDD, 5'd11, 1'b1, 32'h1122_3344, 32'hAABB_1122, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'd5, 2'd0, 32'h0,        32'hAABBCCDD, 5'd12, 1'b1, 32'h1122_3344, 32'h44BB_CCDD, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'd6, 2'd3, 32'h0,        32'hAABBCCDD, 5'd13, 1'b1, 32'h1122_3344, 32'hAABB_CC11, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd2, 2'd1, 32'h0,        32'h0,        5'd14, 1'b1, 32'h1122_3344, 32'h0000_3344, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 4'd4, 2'd2, 32'h0,        32'h0,        5'd15, 1'b1, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 4'd4, 2'd0, 32'h0,        32'h0,        5'd0,  1'b1, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd4, 2'd1, 32'h12345678, 32'h0,        5'd16, 1'b1, 32'h1122_3344, 32'h1234_5678, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'd4, 2'd0, 32'h0,        32'h0,        5'd17, 1'b0, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 4'd7, 2'd0, 32'h0,        32'h0,        5'd18, 1'b1, 32'h1122_3344, 32'h0000_0000, 1'b1, 1'b0};

    // reset state
    #2;
    chk("reset_rf_we",    {31'd0, rf_we},    32'd0);
    chk("reset_exc_adel", {31'd0, exc_adel}, 32'd0);
    chk("reset_ld_cnt",   {28'd0, ld_cnt},   32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // vector table: transfer, then present read data the next cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].mtr, vecs[i].op, vecs[i].a, vecs[i].res, vecs[i].rt, vecs[i].wnum, vecs[i].wen);
      mem_rdata = $urandom;
      tick();
      drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_exc_adel", i), {31'd0, exc_adel}, {31'd0, vecs[i].exp_adel});
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
        chk($sformatf("vec%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].wnum});
      end
      tick();
    end

    // LW held across a 3-cycle stall; data from the first cycle is written
    drive(1'b1, 1'b1, 4'd4, 2'd0, 32'd0, 32'd0, 5'd7, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    wb_stall = 1'b1;
    mem_rdata = 32'h1111_2222;
    #1;
    chk("stall_c1_we", {31'd0, rf_we}, 32'd0);
    chk("stall_c1_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    mem_rdata = 32'h0000_DEAD;
    #1;
    chk("stall_c2_we", {31'd0, rf_we}, 32'd0);
    tick();
    tick();
    wb_stall = 1'b0;
    #1;
    chk("stall_end_we", {31'd0, rf_we}, 32'd1);
    chk("stall_end_wdata", rf_wdata, 32'h1111_2222);
    tick();

    // flush during stall with the skid full: slot and skid both cleared
    drive(1'b1, 1'b1, 4'd4, 2'd0, 32'd0, 32'd0, 5'd9, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    wb_stall = 1'b1;
    mem_rdata = 32'hAAAA_0001;
    tick();
    drive(1'b1, 1'b1, 4'd4, 2'd0, 32'd0, 32'd0, 5'd10, 1'b1);
    flush = 1'b1;
    mem_rdata = 32'hBBBB_0002;
    #1;
    chk("flush_cycle_we", {31'd0, rf_we}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    flush = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("flush_after_we", {31'd0, rf_we}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 4'd4, 2'd0, 32'd0, 32'd0, 5'd11, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    mem_rdata = 32'hCCCC_0003;
    #1;
    chk("flush_next_we", {31'd0, rf_we}, 32'd1);
    chk("flush_next_wdata", rf_wdata, 32'hCCCC_0003);
    tick();

    // counter wrap 15 -> 0
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 4'd1, 2'd0, 32'd0, 32'd0, 5'd1, 1'b1);
      mem_rdata = $urandom;
      tick();
      if (cnt_m == 15) break;
    end
    #1;
    chk("wrap_at_15", {28'd0, ld_cnt}, 32'd15);
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    #1;
    chk("wrap_to_0", {28'd0, ld_cnt}, 32'd0);
    tick();

    // randomized traffic, with an asynchronous reset in the middle
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        wb_stall = 1'b1;
        mid_reset("midrst");
      end
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 8)),
            2'($urandom_range(0, 3)),
            $urandom, $urandom,
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
      wb_stall  = ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0;
      flush     = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      mem_rdata = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
